// File: rtl/sqrt_iter_pkg.sv
`default_nettype none
// =============================================================================
// Module   : sqrt_iter_pkg
// Purpose  : Shared state encoding and width helpers for the iterative sqrt unit.
// Revision : 1.0 - initial release
// =============================================================================
package sqrt_iter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic int root_width(input int sizein);
    return sizein + 1;
  endfunction

  function automatic int rad_width(input int sizein);
    return 2 * sizein + 2;
  endfunction

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sqrt_iter_step.sv
`default_nettype none
// =============================================================================
// Module   : sqrt_iter_step
// Purpose  : One restoring square-root digit step (combinational).
// Revision : 1.0 - initial release
// =============================================================================
module sqrt_iter_step #(
  parameter int N = 17
) (
  input  logic [N:0]   i_rem,
  input  logic [N-1:0] i_root,
  input  logic [1:0]   i_bits,
  output logic [N:0]   o_rem,
  output logic [N-1:0] o_root
);

  logic [N+2:0] w_shift;
  logic [N+3:0] w_diff;
  logic         w_keep;

  // Extra top bit of w_diff acts as the borrow/sign of the trial subtraction.
  assign w_shift = {i_rem, i_bits};
  assign w_diff  = {1'b0, w_shift} - {2'b00, i_root, 2'b01};
  assign w_keep  = ~w_diff[N+3];
  assign o_rem   = w_keep ? w_diff[N:0] : w_shift[N:0];
  assign o_root  = {i_root[N-2:0], w_keep};

  // The partial remainder never exceeds 2*root, so these bits are always zero.
  logic w_unused;
  assign w_unused = &{1'b0, w_diff[N+2:N+1], w_shift[N+2:N+1], i_root[N-1]};

endmodule
`default_nettype wire

// File: rtl/sqrt_iter_unit.sv
`default_nettype none
// =============================================================================
// Module   : sqrt_iter_unit
// Purpose  : Iterative unsigned integer square root, one root bit per cycle,
//            valid/ready in and out. Define SQRT_ROUND_EN for round-to-nearest.
// Revision : 1.0 - initial release
// =============================================================================
module sqrt_iter_unit
  import sqrt_iter_pkg::*;
#(
  parameter int SIZEIN = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2*SIZEIN+1:0]         radicand,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SIZEIN:0]             root,
  output logic [SIZEIN+1:0]           remainder,
  output logic                        neg_err
);

  localparam int N  = root_width(SIZEIN);
  localparam int RW = rad_width(SIZEIN);
  localparam int CW = cnt_width(N);

  state_t        r_state;
  state_t        w_state_nx;
  logic [RW-1:0] r_rad;
  logic [N:0]    r_prem;
  logic [N-1:0]  r_proot;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_root_o;
  logic [N:0]    r_rem_o;
  logic          r_neg;

  logic [N:0]    w_rem_nx;
  logic [N-1:0]  w_root_nx;
  logic          w_last;

  sqrt_iter_step #(.N(N)) u_step (
    .i_rem  (r_prem),
    .i_root (r_proot),
    .i_bits (r_rad[RW-1:RW-2]),
    .o_rem  (w_rem_nx),
    .o_root (w_root_nx)
  );

  assign w_last = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (ce && in_valid) w_state_nx = radicand[RW-1] ? S_DONE : S_CALC;
`ifdef SQRT_ROUND_EN
      S_CALC:  if (ce && w_last) w_state_nx = S_ROUND;
      S_ROUND: if (ce) w_state_nx = S_DONE;
`else
      S_CALC:  if (ce && w_last) w_state_nx = S_DONE;
`endif
      S_DONE: if (ce && out_ready) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rad    <= '0;
      r_prem   <= '0;
      r_proot  <= '0;
      r_cnt    <= '0;
      r_root_o <= '0;
      r_rem_o  <= '0;
      r_neg    <= 1'b0;
    end else if (ce) begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (radicand[RW-1]) begin
              r_root_o <= '0;
              r_rem_o  <= '0;
              r_neg    <= 1'b1;
            end else begin
              r_rad   <= radicand;
              r_prem  <= '0;
              r_proot <= '0;
              r_cnt   <= '0;
            end
          end
        end
        S_CALC: begin
          r_rad   <= {r_rad[RW-3:0], 2'b00};
          r_prem  <= w_rem_nx;
          r_proot <= w_root_nx;
          r_cnt   <= r_cnt + CW'(1);
`ifndef SQRT_ROUND_EN
          if (w_last) begin
            r_root_o <= w_root_nx;
            r_rem_o  <= w_rem_nx;
          end
`endif
        end
`ifdef SQRT_ROUND_EN
        // Remainder above the floor root means the true root is past the .5 point.
        S_ROUND: begin
          r_root_o <= r_proot + {{(N-1){1'b0}}, (r_prem > {1'b0, r_proot})};
          r_rem_o  <= r_prem;
        end
`endif
        S_DONE: if (out_ready) r_neg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign root      = r_root_o;
  assign remainder = r_rem_o;
  assign neg_err   = r_neg;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_iter_unit.sv
`default_nettype none
// =============================================================================
// Module   : tb_sqrt_iter_unit
// Purpose  : Self-checking bench for sqrt_iter_unit (SIZEIN=16), both builds.
// Revision : 1.0 - initial release
// =============================================================================
module tb_sqrt_iter_unit;

  localparam int SIZEIN = 16;
`ifdef SQRT_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  // Latency = clock edges after the accepting edge until out_valid is seen.
  localparam int LAT = SIZEIN + 1 + RND;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [33:0] radicand = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [16:0] root;
  logic [17:0] remainder;
  logic        neg_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sqrt_iter_unit #(.SIZEIN(SIZEIN)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .radicand(radicand), .out_valid(out_valid), .out_ready(out_ready),
    .root(root), .remainder(remainder), .neg_err(neg_err)
  );

  typedef struct {
    logic [33:0] rad;
    longint      root_fl;
    longint      root_rn;
    longint      rem;
    bit          neg;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint isqrt(input longint x);
    longint lo = 0;
    longint hi = 64'd1 << 17;
    longint mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  task automatic model(input logic [33:0] rad, output longint r, output longint m,
                       output bit n, output int lat);
    longint x;
    longint fl;
    if (rad[33]) begin
      r = 0; m = 0; n = 1'b1; lat = 0;
    end else begin
      x  = longint'(rad);
      fl = isqrt(x);
      m  = x - fl * fl;
      r  = (RND != 0 && m > fl) ? fl + 1 : fl;
      n  = 1'b0;
      lat = LAT;
    end
  endtask

  task automatic run_op(input string name, input logic [33:0] rad, input longint exp_root,
                        input longint exp_rem, input bit exp_neg, input int exp_lat);
    int cyc;
    ce = 1'b1;
    out_ready = 1'b1;
    chk({name, "_in_ready"}, longint'(in_ready), 1);
    in_valid = 1'b1;
    radicand = rad;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    chk({name, "_lat"}, cyc, exp_lat);
    chk({name, "_root"}, longint'(root), exp_root);
    chk({name, "_rem"}, longint'(remainder), exp_rem);
    chk({name, "_neg"}, longint'(neg_err), longint'(exp_neg));
    tick();
    chk({name, "_vld_drop"}, longint'(out_valid), 0);
    chk({name, "_root_held"}, longint'(root), exp_root);
  endtask

  initial begin
    longint er, em;
    bit     en;
    int     el;
    int     cyc;
    int     seen;
    logic [33:0] rad;

    vecs[0] = '{34'd144,         12,    12,    0,      1'b0};
    vecs[1] = '{34'd8589934591,  92681, 92682, 166830, 1'b0};
    vecs[2] = '{34'd21,          4,     5,     5,      1'b0};
    vecs[3] = '{34'd20,          4,     4,     4,      1'b0};
    vecs[4] = '{34'd0,           0,     0,     0,      1'b0};
    vecs[5] = '{34'd1,           1,     1,     0,      1'b0};
    vecs[6] = '{34'd3,           1,     2,     2,      1'b0};
    vecs[7] = '{34'h3FFFFFFFB,   0,     0,     0,      1'b1};
    vecs[8] = '{34'h200000000,   0,     0,     0,      1'b1};
    vecs[9] = '{34'd65536,       256,   256,   0,      1'b0};

    rst = 1'b1;
    tick();
    tick();
    chk("rst_in_ready",  longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_root",      longint'(root), 0);
    chk("rst_rem",       longint'(remainder), 0);
    chk("rst_neg",       longint'(neg_err), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].rad,
             (RND != 0) ? vecs[i].root_rn : vecs[i].root_fl,
             vecs[i].rem, vecs[i].neg, vecs[i].neg ? 0 : LAT);
    end

    // Back-pressure: result must hold and new requests be ignored.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    radicand  = 34'd21;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("hold_lat", cyc, LAT);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      radicand = 34'd144;
      tick();
      chk("hold_valid", longint'(out_valid), 1);
      chk("hold_in_ready", longint'(in_ready), 0);
      chk("hold_root", longint'(root), (RND != 0) ? 5 : 4);
      chk("hold_rem", longint'(remainder), 5);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("hold_release_valid", longint'(out_valid), 0);
    chk("hold_release_idle", longint'(in_ready), 1);

    // Clock-enable gap mid-calculation stretches latency.
    in_valid = 1'b1;
    radicand = 34'd144;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      ce = !(i >= 6 && i <= 8);
      tick();
      cyc = i;
      if (out_valid) break;
    end
    ce = 1'b1;
    chk("ce_lat", cyc, LAT + 3);
    chk("ce_root", longint'(root), 12);
    tick();
    chk("ce_drop", longint'(out_valid), 0);

    // Reset mid-calculation discards the operation.
    in_valid = 1'b1;
    radicand = 34'd8589934591;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", longint'(in_ready), 1);
    chk("midrst_out_valid", longint'(out_valid), 0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("midrst_no_result", seen, 0);
    run_op("after_rst", 34'd20, 4, 4, 1'b0, LAT);

    // Randomised operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rad = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rad = 34'($urandom_range(0, 1000));
        1: rad[33] = 1'b0;
        2: rad[33] = 1'b1;
        default: begin
          el  = int'($urandom_range(0, 92681));
          rad = 34'(longint'(el) * longint'(el) + longint'($urandom_range(0, 2 * el)));
        end
      endcase
      model(rad, er, em, en, el);
      run_op($sformatf("rnd%0d", i), rad, er, em, en, el);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
